// File: rtl/weight_addr_gen.sv
// weight_addr_gen
// ---------------------------------------------------------------------------
// Generates the weight-fetch address stream for one convolution layer.
// The sweep walks kernel, row and column indices (column fastest, then row,
// then kernel). Each beat packs LANES consecutive positions.
//
// Optional feature macro: ADDR_GEN_ABORT_EN
//   When defined, an extra 'abort' input cancels a sweep in LOAD/RUN.
//
// Ports:
//   clock       in   single clock, rising edge
//   reset       in   synchronous, active-high
//   start       in   one-cycle pulse, launches a sweep (only honoured in IDLE)
//   cfg_rows    in   kernel height (count)
//   cfg_cols    in   kernel width (count)
//   cfg_kers    in   number of kernels (count)
//   ready       in   downstream accepts the current beat
//   abort       in   (ADDR_GEN_ABORT_EN only) cancel the running sweep
//   row_out     out  packed row addresses, lane 0 in the low bits
//   col_out     out  packed column addresses
//   ker_out     out  packed kernel addresses
//   lane_mask   out  bit i set when lane i holds a valid position
//   addr_valid  out  beat on the outputs is valid
//   busy        out  high while streaming beats
//   done        out  one-cycle pulse after the final beat is accepted
// ---------------------------------------------------------------------------
module weight_addr_gen #(
  parameter int ADDR_W = 5,
  parameter int LANES  = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       cfg_rows,
  input  logic [ADDR_W-1:0]       cfg_cols,
  input  logic [ADDR_W-1:0]       cfg_kers,
  input  logic                    ready,
`ifdef ADDR_GEN_ABORT_EN
  input  logic                    abort,
`endif
  output logic [ADDR_W*LANES-1:0] row_out,
  output logic [ADDR_W*LANES-1:0] col_out,
  output logic [ADDR_W*LANES-1:0] ker_out,
  output logic [LANES-1:0]        lane_mask,
  output logic                    addr_valid,
  output logic                    busy,
  output logic                    done
);

  localparam int VEC_W = ADDR_W * LANES;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, FIN} state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] rows_reg;
  logic [ADDR_W-1:0] cols_reg;
  logic [ADDR_W-1:0] kers_reg;
  logic [ADDR_W-1:0] cur_r_reg;
  logic [ADDR_W-1:0] cur_c_reg;
  logic [ADDR_W-1:0] cur_k_reg;
  // Set when the beat currently on the outputs contains the final position.
  logic              last_reg;

  // Next beat, built combinationally from the cursor.
  logic [VEC_W-1:0]  beat_row;
  logic [VEC_W-1:0]  beat_col;
  logic [VEC_W-1:0]  beat_ker;
  logic [LANES-1:0]  beat_mask;
  logic [ADDR_W-1:0] walk_r;
  logic [ADDR_W-1:0] walk_c;
  logic [ADDR_W-1:0] walk_k;
  logic              beat_last;

  logic              abort_hit;
  logic              cfg_zero;
  logic              load_en;

`ifdef ADDR_GEN_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  assign cfg_zero = (rows_reg == '0) || (cols_reg == '0) || (kers_reg == '0);

  // A new beat is registered when LOAD starts a non-empty sweep, or when the
  // current RUN beat is accepted and more positions remain.
  assign load_en = !abort_hit &&
                   (((state_reg == LOAD) && !cfg_zero) ||
                    ((state_reg == RUN) && ready && !last_reg));

  // Walk the cursor through LANES positions. Once the walk has stepped past
  // the final position (k == kers) it freezes there, so the kernel index never
  // grows beyond kers and the remaining lanes read as empty.
  always_comb begin
    walk_r    = cur_r_reg;
    walk_c    = cur_c_reg;
    walk_k    = cur_k_reg;
    beat_row  = '0;
    beat_col  = '0;
    beat_ker  = '0;
    beat_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      if (walk_k < kers_reg) begin
        beat_row[i*ADDR_W +: ADDR_W] = walk_r;
        beat_col[i*ADDR_W +: ADDR_W] = walk_c;
        beat_ker[i*ADDR_W +: ADDR_W] = walk_k;
        beat_mask[i]                 = 1'b1;
        if ((walk_c + ADDR_W'(1)) == cols_reg) begin
          walk_c = '0;
          if ((walk_r + ADDR_W'(1)) == rows_reg) begin
            walk_r = '0;
            walk_k = walk_k + ADDR_W'(1);
          end else begin
            walk_r = walk_r + ADDR_W'(1);
          end
        end else begin
          walk_c = walk_c + ADDR_W'(1);
        end
      end
    end
    // Having walked past the final position means this beat ends the sweep.
    beat_last = (walk_k == kers_reg);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= IDLE;
      rows_reg   <= '0;
      cols_reg   <= '0;
      kers_reg   <= '0;
      cur_r_reg  <= '0;
      cur_c_reg  <= '0;
      cur_k_reg  <= '0;
      last_reg   <= 1'b0;
      row_out    <= '0;
      col_out    <= '0;
      ker_out    <= '0;
      lane_mask  <= '0;
      addr_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            rows_reg  <= cfg_rows;
            cols_reg  <= cfg_cols;
            kers_reg  <= cfg_kers;
            cur_r_reg <= '0;
            cur_c_reg <= '0;
            cur_k_reg <= '0;
            state_reg <= LOAD;
          end
        end
        LOAD: begin
          if (abort_hit) begin
            state_reg <= IDLE;
          end else if (cfg_zero) begin
            // Empty sweep: no beats, just the completion pulse.
            done      <= 1'b1;
            state_reg <= FIN;
          end else begin
            addr_valid <= 1'b1;
            busy       <= 1'b1;
            state_reg  <= RUN;
          end
        end
        RUN: begin
          if (abort_hit) begin
            addr_valid <= 1'b0;
            lane_mask  <= '0;
            busy       <= 1'b0;
            state_reg  <= IDLE;
          end else if (ready && last_reg) begin
            addr_valid <= 1'b0;
            lane_mask  <= '0;
            busy       <= 1'b0;
            done       <= 1'b1;
            state_reg  <= FIN;
          end
        end
        FIN: begin
          done      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase

      if (load_en) begin
        row_out   <= beat_row;
        col_out   <= beat_col;
        ker_out   <= beat_ker;
        lane_mask <= beat_mask;
        cur_r_reg <= walk_r;
        cur_c_reg <= walk_c;
        cur_k_reg <= walk_k;
        last_reg  <= beat_last;
      end
    end
  end

endmodule

// File: tb/tb_weight_addr_gen.sv
// tb_weight_addr_gen
// Scoreboard bench for weight_addr_gen: each sweep pushes its expected beats
// (from a nested-loop position enumerator) into a queue; a monitor pops and
// compares every accepted beat. Hand-computed beats are checked afterwards.
module tb_weight_addr_gen;

  localparam int AW = 5;
  localparam int LN = 4;
  localparam int VW = AW * LN;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] cfg_rows;
  logic [AW-1:0] cfg_cols;
  logic [AW-1:0] cfg_kers;
  logic          ready;
`ifdef ADDR_GEN_ABORT_EN
  logic          abort;
`endif
  logic [VW-1:0] row_out;
  logic [VW-1:0] col_out;
  logic [VW-1:0] ker_out;
  logic [LN-1:0] lane_mask;
  logic          addr_valid;
  logic          busy;
  logic          done;

  weight_addr_gen dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .cfg_rows   (cfg_rows),
    .cfg_cols   (cfg_cols),
    .cfg_kers   (cfg_kers),
    .ready      (ready),
`ifdef ADDR_GEN_ABORT_EN
    .abort      (abort),
`endif
    .row_out    (row_out),
    .col_out    (col_out),
    .ker_out    (ker_out),
    .lane_mask  (lane_mask),
    .addr_valid (addr_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [VW-1:0] row;
    logic [VW-1:0] col;
    logic [VW-1:0] ker;
    logic [LN-1:0] mask;
  } beat_t;

  beat_t exp_q[$];
  beat_t seen_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    hs_count = 0;
  int    last_hs_cyc = 0;
  bit    busy_ever = 0;
  bit    hold_prev = 0;
  beat_t held;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compares every accepted beat and checks stability under stall.
  always @(negedge clock) begin
    beat_t cur;
    beat_t e;
    if (!reset) begin
      cur = {row_out, col_out, ker_out, lane_mask};
      if (busy) busy_ever = 1'b1;
      if (hold_prev) check("hold_stable", {addr_valid, cur}, {1'b1, held});
      if (addr_valid && ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat actual=%0h required=none", cur);
        end else begin
          e = exp_q.pop_front();
          check("beat", cur, e);
        end
        $display("beat %0d row=%05h col=%05h ker=%05h mask=%b", hs_count, row_out, col_out, ker_out, lane_mask);
        seen_q.push_back(cur);
        hs_count++;
        last_hs_cyc = cyc;
      end
      hold_prev = addr_valid && !ready;
      held      = cur;
    end else begin
      hold_prev = 1'b0;
    end
  end

  // Reference: enumerate positions with plain nested loops, then chunk.
  task automatic build(input int rows, input int cols, input int kers, output int nbeats);
    logic [AW-1:0] pr[$];
    logic [AW-1:0] pc[$];
    logic [AW-1:0] pk[$];
    beat_t e;
    for (int k = 0; k < kers; k++)
      for (int r = 0; r < rows; r++)
        for (int c = 0; c < cols; c++) begin
          pr.push_back(AW'(r));
          pc.push_back(AW'(c));
          pk.push_back(AW'(k));
        end
    nbeats = (pr.size() + LN - 1) / LN;
    for (int b = 0; b < nbeats; b++) begin
      e = '0;
      for (int l = 0; l < LN; l++) begin
        if (b * LN + l < pr.size()) begin
          e.row[l*AW +: AW] = pr[b*LN + l];
          e.col[l*AW +: AW] = pc[b*LN + l];
          e.ker[l*AW +: AW] = pk[b*LN + l];
          e.mask[l]         = 1'b1;
        end
      end
      exp_q.push_back(e);
    end
  endtask

  // Runs one sweep; call at posedge+1. Optional stall of stall_len cycles
  // while beat number stall_at is on the outputs.
  task automatic run_sweep(input int rows, input int cols, input int kers,
                           input int stall_at, input int stall_len);
    int nbeats;
    int start_cyc;
    int stalled = 0;
    bit got = 0;
    build(rows, cols, kers, nbeats);
    hs_count  = 0;
    busy_ever = 0;
    seen_q.delete();
    $display("sweep rows=%0d cols=%0d kers=%0d stall_at=%0d expecting %0d beats", rows, cols, kers, stall_at, nbeats);
    cfg_rows  = AW'(rows);
    cfg_cols  = AW'(cols);
    cfg_kers  = AW'(kers);
    start     = 1'b1;
    start_cyc = cyc;
    @(posedge clock); #1;
    start = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      if (done) begin
        got = 1;
        break;
      end
      if (stall_at >= 0 && hs_count == stall_at && addr_valid && stalled < stall_len) begin
        ready = 1'b0;
        stalled++;
      end else begin
        ready = 1'b1;
      end
      @(posedge clock); #1;
    end
    check("done_seen", got, 1);
    if (got) check("done_cycle", cyc, (nbeats == 0) ? start_cyc + 2 : last_hs_cyc + 1);
    check("beat_count", hs_count, nbeats);
    check("queue_empty", exp_q.size(), 0);
    if (nbeats == 0) check("busy_stays_low", busy_ever, 0);
    ready = 1'b1;
    @(posedge clock); #1;
    check("done_one_cycle", done, 0);
    exp_q.delete();
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    cfg_rows = '0;
    cfg_cols = '0;
    cfg_kers = '0;
    ready    = 1'b1;
`ifdef ADDR_GEN_ABORT_EN
    abort    = 1'b0;
`endif
    repeat (3) @(posedge clock);
    #1;
    check("reset_outputs", {row_out, col_out, ker_out, lane_mask, addr_valid, busy, done}, 0);
    reset = 1'b0;
    @(posedge clock); #1;

    // 3x3x1: three beats, hand-checked first and last beat.
    run_sweep(3, 3, 1, -1, 0);
    check("seen_3x3x1", seen_q.size(), 3);
    if (seen_q.size() == 3) begin
      check("b0_row", seen_q[0].row, {5'd1, 5'd0, 5'd0, 5'd0});
      check("b0_col", seen_q[0].col, {5'd0, 5'd2, 5'd1, 5'd0});
      check("b2_mask", seen_q[2].mask, 4'b0001);
      check("b2_lane0", {seen_q[2].row, seen_q[2].col, seen_q[2].ker}, {15'd0, 5'd2, 15'd0, 5'd2, 20'd0});
    end

    // 2x2x2: two full beats, second beat all kernel 1.
    run_sweep(2, 2, 2, -1, 0);
    check("seen_2x2x2", seen_q.size(), 2);
    if (seen_q.size() == 2) begin
      check("b0_mask", seen_q[0].mask, 4'b1111);
      check("b1_mask", seen_q[1].mask, 4'b1111);
      check("b1_ker", seen_q[1].ker, {5'd1, 5'd1, 5'd1, 5'd1});
    end

    // Backpressure on beat 1 of a 3x3x2 sweep.
    run_sweep(3, 3, 2, 1, 5);

    // Zero config: no beats, done two cycles after start.
    run_sweep(3, 0, 2, -1, 0);

    // Reset mid-sweep; a start during the sweep must be ignored.
    begin
      int nb;
      build(5, 5, 4, nb);
      hs_count = 0;
      cfg_rows = 5'd5;
      cfg_cols = 5'd5;
      cfg_kers = 5'd4;
      start    = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      @(posedge clock); #1;
      cfg_rows = 5'd1;
      cfg_cols = 5'd1;
      cfg_kers = 5'd1;
      start    = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      check("reset_mid_sweep", {row_out, col_out, ker_out, lane_mask, addr_valid, busy, done}, 0);
      reset = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 3; i++) begin
        @(posedge clock); #1;
        check("no_done_after_reset", {addr_valid, done}, 0);
      end
    end
    run_sweep(5, 5, 4, -1, 0);

`ifdef ADDR_GEN_ABORT_EN
    begin
      int nb;
      bit hit = 0;
      build(5, 5, 4, nb);
      hs_count = 0;
      cfg_rows = 5'd5;
      cfg_cols = 5'd5;
      cfg_kers = 5'd4;
      start    = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      for (int t = 0; t < 200; t++) begin
        if (hs_count == 3 && addr_valid) begin
          hit = 1;
          break;
        end
        @(posedge clock); #1;
      end
      check("abort_reached_beat3", hit, 1);
      abort = 1'b1;
      @(posedge clock); #1;
      abort = 1'b0;
      check("abort_outputs", {addr_valid, lane_mask, busy, done}, 0);
      exp_q.delete();
    end
    run_sweep(2, 2, 2, -1, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
